// File: rtl/uart_core_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param_if
// Description : TX handshake, serial lines and RX result bundle for the UART core.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 txd;
    logic                 rxd;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport slave (
        input  tx_valid, tx_data, rxd,
        output tx_ready, tx_busy, txd,
        output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport master (
        output tx_valid, tx_data, rxd,
        input  tx_ready, tx_busy, txd,
        input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param
// Description : Parameterised UART transmitter/receiver sharing one oversample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic [DIV_WIDTH-1:0] baud_div,
    uart_core_param_if.slave          bus
);

    localparam int                  c_OS_W         = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0]   c_OS_LAST      = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]   c_OS_HALF_LAST = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]          c_DATA_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]          c_STOP_LAST    = 4'(STOP_BITS - 1);
    localparam logic                c_PAR_EN       = (PARITY_EN != 0);
    localparam logic                c_PAR_ODD      = (PARITY_ODD != 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Oversample tick; the divisor is re-latched only at wrap so a
    // mid-count change never produces a short period.
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_tick_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_os_tick;

    assign w_os_tick = (r_tick_cnt == r_div);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_div      <= baud_div;
        end else if (w_os_tick) begin
            r_tick_cnt <= '0;
            r_div      <= baud_div;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           r_tx_state;
    logic [c_OS_W-1:0]    r_tx_os;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_txd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= c_ST_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else if (r_tx_state == c_ST_IDLE) begin
            if (bus.tx_valid) begin
                r_tx_shift <= bus.tx_data;
                r_tx_par   <= (^bus.tx_data) ^ c_PAR_ODD;
                r_tx_os    <= '0;
                r_txd      <= 1'b0;
                r_tx_state <= c_ST_START;
            end
        end else if (w_os_tick) begin
            if (r_tx_os != c_OS_LAST) begin
                r_tx_os <= r_tx_os + 1'b1;
            end else begin
                r_tx_os <= '0;
                // txd is loaded with the level of the bit being entered
                case (r_tx_state)
                    c_ST_START: begin
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= c_ST_DATA;
                    end
                    c_ST_DATA: begin
                        if (r_tx_bit == c_DATA_LAST) begin
                            r_tx_bit <= '0;
                            if (c_PAR_EN) begin
                                r_txd      <= r_tx_par;
                                r_tx_state <= c_ST_PARITY;
                            end else begin
                                r_txd      <= 1'b1;
                                r_tx_state <= c_ST_STOP;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end
                    c_ST_PARITY: begin
                        r_tx_bit   <= '0;
                        r_txd      <= 1'b1;
                        r_tx_state <= c_ST_STOP;
                    end
                    c_ST_STOP: begin
                        if (r_tx_bit == c_STOP_LAST) begin
                            r_tx_state <= c_ST_IDLE;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                    default: begin
                        r_txd      <= 1'b1;
                        r_tx_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.txd      = r_txd;
    assign bus.tx_ready = (r_tx_state == c_ST_IDLE) && !reset;
    assign bus.tx_busy  = (r_tx_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // Receiver input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [2:0]           r_rx_state;
    logic [c_OS_W-1:0]    r_rx_os;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state   <= c_ST_IDLE;
            r_rx_os      <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                c_ST_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_os    <= '0;
                        r_rx_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_os_tick) begin
                        if (r_rx_os != c_OS_HALF_LAST) begin
                            r_rx_os <= r_rx_os + 1'b1;
                        end else begin
                            r_rx_os    <= '0;
                            r_rx_bit   <= '0;
                            // line high at the start-bit centre means a glitch
                            r_rx_state <= r_rx_sync ? c_ST_IDLE : c_ST_DATA;
                        end
                    end
                end
                default: begin
                    if (w_os_tick) begin
                        if (r_rx_os != c_OS_LAST) begin
                            r_rx_os <= r_rx_os + 1'b1;
                        end else begin
                            r_rx_os <= '0;
                            if (r_rx_state == c_ST_DATA) begin
                                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                                if (r_rx_bit == c_DATA_LAST) begin
                                    r_rx_state <= c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                                end else begin
                                    r_rx_bit <= r_rx_bit + 1'b1;
                                end
                            end else if (r_rx_state == c_ST_PARITY) begin
                                r_rx_par_bit <= r_rx_sync;
                                r_rx_state   <= c_ST_STOP;
                            end else begin
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= r_rx_shift;
                                r_rx_perr  <= c_PAR_EN &
                                              (((^r_rx_shift) ^ c_PAR_ODD) != r_rx_par_bit);
                                r_rx_ferr  <= ~r_rx_sync;
                                r_rx_state <= c_ST_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
    // No read-acknowledge exists yet, so overrun is reserved and tied low.
    assign bus.rx_overrun    = 1'b0;

endmodule
`default_nettype wire
